// File: rtl/mem_play_arbiter.sv
// 32x8 byte memory with one access slot per cycle shared between a host write
// port, a host read port and a bit-serial LED playback engine.
module mem_play_arbiter #(
  parameter int DEPTH    = 32,
  parameter int DW       = 8,
  parameter int TICK_DIV = 100_000_000
) (
  input  logic          clock_50Mhz,
  input  logic          reset,
  input  logic          wr_req,
  input  logic [4:0]    wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  input  logic          rd_req,
  input  logic [4:0]    rd_addr,
  output logic          rd_ack,
  output logic [DW-1:0] rd_data,
  input  logic          play_en,
  output logic          led,
  output logic          play_wrap,
  output logic          init_done
);
  localparam int AW = 5;
  localparam int BW = $clog2(DW);
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [BW-1:0] LAST_BIT  = BW'(DW - 1);
  localparam logic [CW-1:0] TICK_LAST = CW'(TICK_DIV - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;
  typedef enum logic {HOST_WRITE, HOST_READ} host_t;

  state_t state, next_state;
  host_t  last_host;

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] init_addr, play_addr, mem_addr;
  logic [BW-1:0] bit_idx;
  logic [CW-1:0] tick_cnt;
  logic [DW-1:0] cur_byte, mem_wdata, mem_rdata;
  logic          fetch_pending, play_en_d, mem_we;
  logic          fetch_grant, wr_grant, rd_grant;
  logic          wr_elig, rd_elig;

  // A port whose ack is showing this cycle sits out one arbitration round.
  assign wr_elig = wr_req && !wr_ack;
  assign rd_elig = rd_req && !rd_ack;

  // NOTE: every output of a combinational block gets a default first;
  // a path that leaves one unassigned infers a latch.
  always_comb begin
    next_state  = state;
    fetch_grant = 1'b0;
    wr_grant    = 1'b0;
    rd_grant    = 1'b0;
    mem_we      = 1'b0;
    mem_addr    = rd_addr;
    mem_wdata   = wr_data;
    if (!reset) begin
      if (state == ST_INIT) begin
        mem_we    = 1'b1;
        mem_addr  = init_addr;
        mem_wdata = DW'(init_addr);
        if (init_addr == LAST_ADDR) next_state = ST_RUN;
      end else if (fetch_pending && play_en) begin
        fetch_grant = 1'b1;
        mem_addr    = play_addr;
      end else if (wr_elig && (!rd_elig || last_host == HOST_READ)) begin
        wr_grant = 1'b1;
        mem_we   = 1'b1;
        mem_addr = wr_addr;
      end else if (rd_elig) begin
        rd_grant = 1'b1;
      end
    end
  end

  assign mem_rdata = mem[mem_addr];

  // NOTE: the storage array has no reset branch; INIT rewrites every word,
  // and leaving reset off lets it map onto plain RAM.
  always_ff @(posedge clock_50Mhz) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock_50Mhz) begin
    if (reset) state <= ST_INIT;
    else       state <= next_state;
  end

  always_ff @(posedge clock_50Mhz) begin
    if (reset) begin
      init_addr     <= '0;
      init_done     <= 1'b0;
      wr_ack        <= 1'b0;
      rd_ack        <= 1'b0;
      rd_data       <= '0;
      last_host     <= HOST_READ;
      play_en_d     <= 1'b0;
      play_addr     <= '0;
      bit_idx       <= '0;
      tick_cnt      <= '0;
      fetch_pending <= 1'b0;
      cur_byte      <= '0;
      led           <= 1'b0;
      play_wrap     <= 1'b0;
    end else begin
      wr_ack    <= wr_grant;
      rd_ack    <= rd_grant;
      play_wrap <= 1'b0;
      if (rd_grant) rd_data <= mem_rdata;
      if (wr_grant)      last_host <= HOST_WRITE;
      else if (rd_grant) last_host <= HOST_READ;

      if (state == ST_INIT) begin
        init_addr <= init_addr + 1'b1;
        if (init_addr == LAST_ADDR) init_done <= 1'b1;
      end else begin
        play_en_d <= play_en;
        if (fetch_grant) begin
          cur_byte      <= mem_rdata;
          fetch_pending <= 1'b0;
        end
        if (!play_en) begin
          led           <= 1'b0;
          tick_cnt      <= '0;
          fetch_pending <= 1'b0;
        end else if (!play_en_d) begin
          play_addr     <= '0;
          bit_idx       <= '0;
          tick_cnt      <= '0;
          fetch_pending <= 1'b1;
        end else if (tick_cnt == TICK_LAST) begin
          // Bit 7 of the held byte is shown while the next byte is fetched.
          tick_cnt <= '0;
          led      <= cur_byte[bit_idx];
          bit_idx  <= bit_idx + 1'b1;
          if (bit_idx == LAST_BIT) begin
            play_addr     <= play_addr + 1'b1;
            fetch_pending <= 1'b1;
            if (play_addr == LAST_ADDR) play_wrap <= 1'b1;
          end
        end else begin
          tick_cnt <= tick_cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: doc/mem_play_arbiter.md
# mem_play_arbiter

Owner and arbiter of a 32×8 byte memory. It shares a single memory access slot per cycle between a host write port, a host read port and an internal bit-serial playback engine. The playback engine shifts memory contents out LSB-first, one bit per `TICK_DIV` clocks, to the board LED. After reset the block self-initialises the memory to `mem[i] = i`.

## Interface
- `DEPTH`, 32: memory words. Fixed at 32; address width is 5.
- `DW`, 8: data width.
- `TICK_DIV`, 100_000_000: clocks per playback bit. Must be ≥ 4.

- `clock_50Mhz`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `wr_req`  in  1  host write request; held high until `wr_ack`.
- `wr_addr`  in  5  write address.
- `wr_data`  in  8  write data.
- `wr_ack`  out  1  one-cycle pulse; the write has completed.
- `rd_req`  in  1  host read request; held high until `rd_ack`.
- `rd_addr`  in  5  read address.
- `rd_ack`  out  1  one-cycle pulse; `rd_data` is valid in this cycle.
- `rd_data`  out  8  read data; holds its value until the next read.
- `play_en`  in  1  playback enable, level-sensitive.
- `led`  out  1  current playback bit; 0 while playback is disabled.
- `play_wrap`  out  1  one-cycle pulse when the playback address wraps 31→0.
- `init_done`  out  1  high once self-initialisation has finished.

## Operation
- **Reset values:** `wr_ack`=0, `rd_ack`=0, `rd_data`=0, `led`=0, `play_wrap`=0, `init_done`=0. Internally: state=INIT, `init_addr`=0, `play_addr`=0, `bit_idx`=0, `tick_cnt`=0, `fetch_pending`=0, `last_host`=READ.
- Reset asserted in any cycle aborts all activity: in-flight acks are dropped and INIT restarts. Memory contents are not cleared by reset itself; INIT rewrites them.
- **State INIT:** each cycle writes `mem[init_addr] = init_addr` (zero-extended to 8 bits), then increments `init_addr`. After the write to address 31 the state moves to RUN and `init_done`=1. Host requests and `play_en` are ignored (not acked, not latched) during INIT.
- **State RUN, slot arbitration each cycle, in priority order:**
  1. `fetch_pending` → playback fetch: `cur_byte <= mem[play_addr]`, then clear `fetch_pending`.
  2. Host requests, with a port not eligible in the cycle its own ack is high.
     - Both eligible: the port opposite `last_host` wins.
     - Only one eligible: that port wins.
  3. Every grant updates `last_host`.
- **Write grant:** `mem[wr_addr] <= wr_data`; `wr_ack`=1 in the next cycle.
- **Read grant:** `rd_data <= mem[rd_addr]`, registered; `rd_ack`=1 in the next cycle.
- A request still high during its ack cycle is treated as a new transaction, granted no earlier than the following cycle.
- **Playback start:** a `play_en` 0→1 transition sampled in RUN sets `play_addr`=0, `bit_idx`=0, `tick_cnt`=0, `fetch_pending`=1.
- **Playback tick:** while `play_en`=1, `tick_cnt` counts 0..`TICK_DIV`−1 and wraps. At terminal count:
  - `led <= cur_byte[bit_idx]`.
  - `bit_idx` increments.
  - When `bit_idx` was 7: `bit_idx`=0, `play_addr` increments (31→0 wraps and pulses `play_wrap`), `fetch_pending`=1.
- `play_en`=0: `led`=0, `tick_cnt` held at 0, no fetches issued. Re-enabling restarts playback from address 0.
- A host write to the byte currently held in `cur_byte` does not alter the bits being played. The new value is seen on the next pass.

## Timing
- INIT lasts 32 cycles after reset deasserts (cycles 0..31). `init_done`=1 from cycle 32.
- Host latency: request in cycle N with no contention → ack in N+1. Under contention, worst case is an ack in N+3.
- Each host port sustains at most one transaction per 2 cycles.
- Playback fetch is always granted in the cycle after it is set. `TICK_DIV` ≥ 4 guarantees `cur_byte` is loaded before its first bit is used.
- `play_en` first sampled high in cycle t:
  - First `led` update is visible in cycle t+1+`TICK_DIV`.
  - Subsequent updates follow every `TICK_DIV` cycles.
- `play_wrap` is coincident with the tick that moves `play_addr` from 31 to 0.

## Test plan
- **Reset/INIT:** deassert reset, then read addresses 0, 17, 31 after `init_done` → `rd_data` = 0x00, 0x11, 0x1F. `init_done` rises exactly 32 cycles after reset deasserts.
- **Contention:** with `TICK_DIV`=4, hold `wr_req` (addr 5, 0xA5) and `rd_req` (addr 5) from the same cycle → grants alternate starting with write. `rd_ack` returns 0xA5, and no ack is ever lost.
- **Playback:** `TICK_DIV`=4, `play_en`=1 after init → `led` = 8×0 (byte 0), then 1,0,0,0,0,0,0,0 (byte 1), one bit per 4 cycles.
- **Wrap:** run playback for 256 bits → `play_wrap` pulses once at the start of bit 256, and byte 0 replays.
- **Fetch priority:** hold `rd_req` continuously during playback → each byte-boundary fetch preempts the read by exactly one cycle, and the `led` pattern is unchanged.
- **Reset mid-operation:** assert reset for 1 cycle during a pending write and active playback → `wr_ack` is never issued, `led`=0, and INIT reruns. Address 5 reads back 0x05.
